alu_clock_gate_ctrl: RTL and testbench

Parametrised, stateful clock-gating controller for the ALU datapath. It replaces fixed combinational AND gating with per-unit glitch-free gated clocks. Each functional unit (arithmetic, logic, shift, and so on) gets a wake handshake and an idle timeout that switches its clock off automatically. The block sits between the top-level clock and the ALU sub-units, and is driven by the opcode decoder's unit-select request.

---
 rtl/alu_clock_gate_ctrl_pkg.sv | 16 +
 rtl/alu_clock_gate_ctrl_cell.sv | 16 +
 rtl/alu_clock_gate_ctrl.sv | 107 ++++++++++
 tb/tb_alu_clock_gate_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_clock_gate_ctrl_pkg.sv
// Shared types and defaults for the ALU clock-gating controller.
package alu_cg_pkg;

  typedef enum logic [1:0] {
    CG_OFF  = 2'b00,
    CG_WAKE = 2'b01,
    CG_ON   = 2'b10
  } cg_state_t;

  localparam int CG_IDLE_CYC_DEF = 4;
  localparam int CG_STAT_W_DEF   = 32;

  localparam int CG_UNIT_AU = 0;
  localparam int CG_UNIT_LU = 1;

endpackage

// File: rtl/alu_clock_gate_ctrl_cell.sv
// Glitch-free clock gate: enable latched while clk is low, then ANDed with clk.
module clock_gate_cell (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic en_l;

  always_latch begin
    if (!clk) en_l = en;
  end

  assign gclk = clk & en_l;

endmodule

// File: rtl/alu_clock_gate_ctrl.sv
// Per-unit clock-gating controller with wake handshake and idle timeout.
// Define ALU_CG_STATS_EN to build per-unit active-cycle counters on stat_cnt.
//
// state   | meaning
// CG_OFF  | unit clock gated off
// CG_WAKE | gate enabled, first gclk edge pending, request not yet accepted
// CG_ON   | clock running, requests accepted, idle counter counting down
module alu_clock_gate_ctrl
  import alu_cg_pkg::*;
#(
  parameter int N_UNITS  = 2,
  parameter int IDLE_CYC = CG_IDLE_CYC_DEF,
  parameter int UNIT_W   = (N_UNITS > 1) ? $clog2(N_UNITS) : 1,
  parameter int STAT_W   = CG_STAT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      req_valid,
  input  logic [UNIT_W-1:0]         req_unit,
  output logic                      req_ready,
  output logic [N_UNITS-1:0]        gclk,
  output logic [N_UNITS-1:0]        unit_on,
`ifdef ALU_CG_STATS_EN
  output logic [N_UNITS*STAT_W-1:0] stat_cnt,
`endif
  output logic                      err_unit
);

  localparam int CNT_W = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYC);

  logic [N_UNITS-1:0] accept;
  logic [N_UNITS-1:0] cell_gclk;
  logic               range_err;

  assign range_err = req_valid && (int'(req_unit) >= N_UNITS);
  assign req_ready = |accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_unit <= 1'b0;
    end else if (range_err) begin
      err_unit <= 1'b1;
    end
  end

  for (genvar u = 0; u < N_UNITS; u++) begin : g_unit
    cg_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             hit;

    assign hit       = enable && req_valid && (req_unit == UNIT_W'(u));
    assign accept[u] = hit && (state == CG_ON);
    assign unit_on[u] = (state != CG_OFF);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= CG_OFF;
        cnt   <= '0;
      end else if (!enable) begin
        state <= CG_OFF;
        cnt   <= '0;
      end else begin
        case (state)
          CG_OFF: begin
            if (hit) state <= CG_WAKE;
          end
          CG_WAKE: begin
            state <= CG_ON;
            cnt   <= IDLE_LD;
          end
          CG_ON: begin
            if (hit) cnt <= IDLE_LD;
            else if (cnt == '0) state <= CG_OFF;
            else cnt <= cnt - CNT_W'(1);
          end
          default: state <= CG_OFF;
        endcase
      end
    end

    clock_gate_cell u_cg (
      .clk  (clk),
      .en   (unit_on[u]),
      .gclk (cell_gclk[u])
    );

    // Reset kills the gated clock immediately, even mid high phase.
    assign gclk[u] = cell_gclk[u] & rst_n;

`ifdef ALU_CG_STATS_EN
    logic [STAT_W-1:0] scnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        scnt <= '0;
      end else if (unit_on[u] && (scnt != '1)) begin
        scnt <= scnt + STAT_W'(1);
      end
    end

    assign stat_cnt[u*STAT_W +: STAT_W] = scnt;
`endif
  end

endmodule

// File: tb/tb_alu_clock_gate_ctrl.sv
// Scoreboard bench for alu_clock_gate_ctrl with a timestamp-based reference model.
module tb_alu_clock_gate_ctrl;

  localparam int N    = 2;
  localparam int IDLE = 4;
  localparam int UW   = 2;
  localparam int SW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          req_valid = 1'b0;
  logic [UW-1:0] req_unit = '0;
  logic          req_ready;
  logic [N-1:0]  gclk;
  logic [N-1:0]  unit_on;
  logic          err_unit;
`ifdef ALU_CG_STATS_EN
  logic [N*SW-1:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  alu_clock_gate_ctrl #(
    .N_UNITS  (N),
    .IDLE_CYC (IDLE),
    .UNIT_W   (UW),
    .STAT_W   (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req_valid (req_valid),
    .req_unit  (req_unit),
    .req_ready (req_ready),
    .gclk      (gclk),
    .unit_on   (unit_on),
`ifdef ALU_CG_STATS_EN
    .stat_cnt  (stat_cnt),
`endif
    .err_unit  (err_unit)
  );

  typedef struct {
    logic          ready;
    logic [N-1:0]  on;
    logic          err;
    logic [N-1:0]  ghi;
    logic [N*SW-1:0] stat;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // Model: a unit is on for every cycle up to last_on, accepts from ready_from.
  int           cyc;
  int           last_on [N];
  int           ready_from [N];
  int           m_stat [N];
  logic         m_err;
  logic [N-1:0] prev_on;
  logic         m_ready_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      last_on[i] = -1;
      ready_from[i] = 0;
      m_stat[i] = 0;
    end
    m_err = 1'b0;
    prev_on = '0;
    m_ready_last = 1'b0;
  endfunction

  task automatic step(input logic en, input logic v, input logic [UW-1:0] u);
    exp_t e;
    int iu;
    @(posedge clk);
    #2;
    enable = en;
    req_valid = v;
    req_unit = u;
    iu = int'(u);
    e.ghi = prev_on;
    e.err = m_err;
    e.stat = '0;
    for (int i = 0; i < N; i++) begin
      e.on[i] = (cyc <= last_on[i]);
      e.stat[i*SW +: SW] = SW'(m_stat[i]);
    end
    e.ready = 1'b0;
    if (iu < N) e.ready = en && v && e.on[iu] && (cyc >= ready_from[iu]);
    sb.push_back(e);
    m_ready_last = e.ready;
    for (int i = 0; i < N; i++) begin
      if (!en) begin
        if (last_on[i] > cyc) last_on[i] = cyc;
      end else if (v && iu == i) begin
        if (!e.on[i]) begin
          ready_from[i] = cyc + 2;
          last_on[i] = cyc + 2 + IDLE;
        end else if (cyc >= ready_from[i]) begin
          last_on[i] = cyc + 1 + IDLE;
        end
      end
      if (e.on[i] && m_stat[i] < (1 << SW) - 1) m_stat[i]++;
    end
    if (v && iu >= N) m_err = 1'b1;
    prev_on = e.on;
    cyc++;
  endtask

  task automatic req_until_ready(input logic [UW-1:0] u, output int k);
    k = 0;
    step(1'b1, 1'b1, u);
    #1;
    while (!req_ready && k < 8) begin
      k++;
      step(1'b1, 1'b1, u);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    req_valid = 1'b0;
    req_unit = '0;
    #1;
    check("rst_gclk", 32'(gclk), 0);
    check("rst_unit_on", 32'(unit_on), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_err", 32'(err_unit), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    logic [N-1:0] ghi;
    forever begin
      @(posedge clk);
      #3;
      ghi = gclk;
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("req_ready", 32'(req_ready), 32'(e.ready));
        check("unit_on", 32'(unit_on), 32'(e.on));
        check("err_unit", 32'(err_unit), 32'(e.err));
        check("gclk_high_phase", 32'(ghi), 32'(e.ghi));
        check("gclk_low_phase", 32'(gclk), 0);
`ifdef ALU_CG_STATS_EN
        check("stat_cnt", 32'(stat_cnt), 32'(e.stat));
`endif
      end
    end
  end

  initial begin : driver
    int k;
    logic cv;
    logic [UW-1:0] cu;
    int r;
    model_reset();
    #1;
    check("init_gclk", 32'(gclk), 0);
    check("init_ready", 32'(req_ready), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Wake from OFF, three accepted requests, then idle shutdown.
    req_until_ready(2'd0, k);
    check("wake_latency", 32'(k), 2);
    step(1'b1, 1'b1, 2'd0);
    step(1'b1, 1'b1, 2'd0);
    repeat (8) step(1'b1, 1'b0, 2'd0);

    // Both units active, enable falls mid-burst, then re-wake.
    req_until_ready(2'd0, k);
    req_until_ready(2'd1, k);
    step(1'b1, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd1);
    #1;
    check("ready_enable_low", 32'(req_ready), 0);
    step(1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    req_until_ready(2'd1, k);
    check("rewake_latency", 32'(k), 2);
    repeat (8) step(1'b1, 1'b0, 2'd0);

    // Out-of-range unit: sticky error until reset.
    step(1'b1, 1'b1, 2'd3);
    #1;
    check("ready_out_of_range", 32'(req_ready), 0);
    repeat (4) step(1'b1, 1'b0, 2'd0);
    do_reset();

    // Randomized decoder traffic.
    cv = 1'b0;
    cu = '0;
    for (int i = 0; i < 400; i++) begin
      if (!cv || m_ready_last || cu >= UW'(N)) begin
        cv = ($urandom_range(0, 2) != 0);
        r = $urandom_range(0, 29);
        cu = (r == 0) ? 2'd3 : (r == 1) ? 2'd2 : UW'(r % 2);
      end else if ($urandom_range(0, 15) == 0) begin
        cu = (cu == 2'd0) ? 2'd1 : 2'd0;
      end
      step($urandom_range(0, 19) != 0, cv, cu);
    end
    repeat (8) step(1'b1, 1'b0, 2'd0);

    // Asynchronous reset while unit 1 is ON with counter 2.
    do_reset();
    req_until_ready(2'd1, k);
    step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0);
    @(posedge clk);
    #2;
    check("gclk1_before_rst", 32'(gclk[1]), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_gclk", 32'(gclk), 0);
    check("async_rst_unit_on", 32'(unit_on), 0);
    check("async_rst_ready", 32'(req_ready), 0);
    check("async_rst_err", 32'(err_unit), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #3;
      check("gclk_in_reset", 32'(gclk), 0);
    end
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (4) step(1'b1, 1'b0, 2'd0);

`ifdef ALU_CG_STATS_EN
    do_reset();
    repeat (22) step(1'b1, 1'b1, 2'd0);
    #1;
    check("stat_au_saturated", 32'(stat_cnt[SW-1:0]), 32'hF);
    check("stat_lu_zero", 32'(stat_cnt[2*SW-1:SW]), 0);
`endif

    repeat (2) @(posedge clk);
    #4;
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
